trex_game_ctrl: RTL and testbench



---
 rtl/trex_game_ctrl.sv | 176 +++++++++++++++++
 tb/tb_trex_game_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trex_game_ctrl.sv
// Game-level controller for the trex runner: frame timing, jump button debounce,
// IDLE/RUN/OVER sequencing, speed ramp, score and hi-score tracking.
module trex_game_ctrl #(
    parameter int unsigned CLK_PER_FRAME     = 1_666_666,
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned SPEED_INIT        = 6,
    parameter int unsigned SPEED_MAX         = 13,
    parameter int unsigned SPEED_STEP_FRAMES = 600,
    parameter int unsigned SCORE_DIV         = 6,
    parameter int unsigned SCORE_MAX         = 9999,
    parameter int unsigned OVER_HOLD_FRAMES  = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_jump,
    input  logic        crash,
    output logic        frame_tick,
    output logic [5:0]  timer,
    output logic [3:0]  speed,
    output logic        jump,
    output logic        game_rst,
    output logic [1:0]  game_state,
    output logic [13:0] score,
    output logic [13:0] hi_score
);

    localparam int unsigned FW = (CLK_PER_FRAME > 1) ? $clog2(CLK_PER_FRAME) : 1;
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SW = (SPEED_STEP_FRAMES > 1) ? $clog2(SPEED_STEP_FRAMES) : 1;
    localparam int unsigned CW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int unsigned HW = $clog2(OVER_HOLD_FRAMES + 1);

    localparam logic [FW-1:0] FRAME_LAST = FW'(CLK_PER_FRAME - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(SPEED_STEP_FRAMES - 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(SCORE_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(OVER_HOLD_FRAMES);
    localparam logic [3:0]    SPD_INIT   = 4'(SPEED_INIT);
    localparam logic [3:0]    SPD_MAX    = 4'(SPEED_MAX);
    localparam logic [13:0]   SCR_MAX    = 14'(SCORE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    logic [FW-1:0] frame_cnt_q;
    logic [5:0]    timer_q;
    logic          sync1_q, sync2_q;
    logic          db_q, db_prev_q;
    logic [DW-1:0] db_cnt_q;
    logic          press;

    state_e        state_q;
    logic          jump_q, game_rst_q;
    logic [HW-1:0] hold_q;
    logic [SW-1:0] step_q;
    logic [3:0]    speed_q;
    logic [CW-1:0] div_q;
    logic [13:0]   score_q, hi_q;

    assign frame_tick = (frame_cnt_q == FRAME_LAST);

    // Frame counter and seconds timer run free in every game state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
            timer_q     <= '0;
        end else begin
            frame_cnt_q <= frame_tick ? '0 : frame_cnt_q + 1'b1;
            if (frame_tick) begin
                timer_q <= (timer_q == 6'd59) ? 6'd0 : timer_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            db_cnt_q  <= '0;
        end else begin
            sync1_q   <= btn_jump;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            // Any cycle where the input agrees with the accepted level restarts the count.
            if (sync2_q != db_q) begin
                if (db_cnt_q == DB_LAST) begin
                    db_q     <= sync2_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    assign press = db_q & ~db_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            jump_q     <= 1'b0;
            game_rst_q <= 1'b0;
            hold_q     <= '0;
            step_q     <= '0;
            speed_q    <= SPD_INIT;
            div_q      <= '0;
            score_q    <= '0;
            hi_q       <= '0;
        end else begin
            jump_q     <= 1'b0;
            game_rst_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (press) begin
                        state_q <= ST_RUN;
                        jump_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (frame_tick) begin
                        if (step_q == STEP_LAST) begin
                            step_q <= '0;
                            if (speed_q < SPD_MAX) speed_q <= speed_q + 4'd1;
                        end else begin
                            step_q <= step_q + 1'b1;
                        end
                    end
                    // The crash cycle never scores, so the hi-score compare sees the final score.
                    if (crash) begin
                        state_q <= ST_OVER;
                        hold_q  <= '0;
                        if (score_q > hi_q) hi_q <= score_q;
                    end else begin
                        if (press) jump_q <= 1'b1;
                        if (frame_tick) begin
                            if (div_q == DIV_LAST) begin
                                div_q <= '0;
                                if (score_q < SCR_MAX) score_q <= score_q + 14'd1;
                            end else begin
                                div_q <= div_q + 1'b1;
                            end
                        end
                    end
                end
                ST_OVER: begin
                    if (frame_tick && hold_q < HOLD_MAX) hold_q <= hold_q + 1'b1;
                    if (press && hold_q >= HOLD_MAX) begin
                        state_q    <= ST_IDLE;
                        game_rst_q <= 1'b1;
                        speed_q    <= SPD_INIT;
                        step_q     <= '0;
                        score_q    <= '0;
                        div_q      <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign timer      = timer_q;
    assign speed      = speed_q;
    assign jump       = jump_q;
    assign game_rst   = game_rst_q;
    assign game_state = state_q;
    assign score      = score_q;
    assign hi_score   = hi_q;

endmodule

// File: tb/tb_trex_game_ctrl.sv
// Bench for trex_game_ctrl: directed game scenarios plus random button/crash
// traffic, every cycle compared against a frame/tick-count reference model.
module tb_trex_game_ctrl;
  localparam int CPF   = 4;
  localparam int DBC   = 3;
  localparam int SPI   = 6;
  localparam int SPM   = 8;
  localparam int SSF   = 2;
  localparam int SDIV  = 2;
  localparam int SMAX  = 9;
  localparam int OHF   = 2;
  localparam int P_LAT = 2 + DBC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_jump = 1'b0;
  logic crash = 1'b0;
  logic frame_tick, jump, game_rst;
  logic [5:0] timer;
  logic [3:0] speed;
  logic [1:0] game_state;
  logic [13:0] score, hi_score;

  trex_game_ctrl #(
    .CLK_PER_FRAME(CPF), .DEBOUNCE_CYCLES(DBC), .SPEED_INIT(SPI), .SPEED_MAX(SPM),
    .SPEED_STEP_FRAMES(SSF), .SCORE_DIV(SDIV), .SCORE_MAX(SMAX), .OVER_HOLD_FRAMES(OHF)
  ) dut (
    .clk(clk), .rst(rst), .btn_jump(btn_jump), .crash(crash),
    .frame_tick(frame_tick), .timer(timer), .speed(speed), .jump(jump),
    .game_rst(game_rst), .game_state(game_state), .score(score), .hi_score(hi_score)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: game progress kept as plain tick counts
  int m_cyc, m_state, m_run_ticks, m_score_ticks, m_over_ticks, m_hi;
  bit m_db, m_db_prev, m_jump, m_grst;
  bit bq[$];
  bit s2q[$];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction
  function automatic bit exp_tick();
    return (m_cyc % CPF) == CPF - 1;
  endfunction
  function automatic int exp_timer();
    return (m_cyc / CPF) % 60;
  endfunction
  function automatic int exp_speed();
    return imin(SPI + m_run_ticks / SSF, SPM);
  endfunction
  function automatic int exp_score();
    return imin(m_score_ticks / SDIV, SMAX);
  endfunction
  function automatic bit m_press();
    return m_db && !m_db_prev;
  endfunction
  function automatic int pred_over();
    int n = m_over_ticks;
    for (int k = m_cyc; k < m_cyc + P_LAT; k++) if (k % CPF == CPF - 1) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_state = 0; m_run_ticks = 0; m_score_ticks = 0;
    m_over_ticks = 0; m_hi = 0; m_db = 0; m_db_prev = 0; m_jump = 0; m_grst = 0;
    bq = '{0, 0};
    s2q = '{0, 0, 0};
  endtask

  task automatic model_step(input bit b, input bit c);
    bit tick, press, flip;
    int sc;
    tick = exp_tick();
    press = m_press();
    sc = exp_score();
    m_jump = press && (m_state == 0 || (m_state == 1 && !c));
    m_grst = (m_state == 2) && press && (m_over_ticks >= OHF);
    case (m_state)
      0: if (press) m_state = 1;
      1: begin
        if (tick) m_run_ticks++;
        if (c) begin
          if (sc > m_hi) m_hi = sc;
          m_state = 2;
          m_over_ticks = 0;
        end else if (tick) begin
          m_score_ticks++;
        end
      end
      default: begin
        if (m_grst) begin
          m_state = 0; m_run_ticks = 0; m_score_ticks = 0;
        end else if (tick) begin
          m_over_ticks++;
        end
      end
    endcase
    s2q.push_back(bq[0]);
    void'(s2q.pop_front());
    flip = (s2q[0] != m_db) && (s2q[1] != m_db) && (s2q[2] != m_db);
    m_db_prev = m_db;
    if (flip) m_db = !m_db;
    bq.push_back(b);
    void'(bq.pop_front());
    m_cyc++;
  endtask

  // scoreboard-side observations
  int n_jump_obs = 0, n_grst_obs = 0, n_tick_obs = 0;
  bit last_jump;
  int snap_state, snap_score, snap_speed, snap_hi;

  task automatic check_all();
    last_jump = jump;
    if (jump) n_jump_obs++;
    if (frame_tick) n_tick_obs++;
    if (game_rst) begin
      n_grst_obs++;
      snap_state = game_state; snap_score = score; snap_speed = speed; snap_hi = hi_score;
    end
    check("frame_tick", frame_tick, exp_tick());
    check("timer", timer, exp_timer());
    check("speed", speed, exp_speed());
    check("jump", jump, m_jump);
    check("game_rst", game_rst, m_grst);
    check("game_state", game_state, m_state);
    check("score", score, exp_score());
    check("hi_score", hi_score, m_hi);
  endtask

  // driver: called at a falling edge; checks this cycle, drives the next
  task automatic step(input bit b, input bit c);
    check_all();
    btn_jump = b;
    crash = c;
    model_step(b, c);
    @(negedge clk);
  endtask

  task automatic press_pulse(input bit crash_on_press, input int n);
    for (int i = 0; i < n; i++) begin
      bit c;
      c = crash_on_press && m_press() && exp_tick() && (m_state == 1);
      step(bit'(i < 3), c);
    end
  endtask

  task automatic wait_run(input int n, input string tag);
    int i = 0;
    while (m_run_ticks < n && i < 200) begin
      step(0, 0);
      i++;
    end
    check(tag, int'(i < 200), 1);
  endtask

  task automatic wait_over_ready();
    int i = 0;
    while (!(m_state == 2 && m_over_ticks >= OHF && !m_db && !m_db_prev) && i < 100) begin
      step(0, 0);
      i++;
    end
    check("wait_over_ready", int'(i < 100), 1);
  endtask

  initial begin
    int j0, g0, first, seg, ok;
    bit b, c;

    repeat (3) @(negedge clk);
    check("rst_frame_tick", frame_tick, 0);
    check("rst_timer", timer, 0);
    check("rst_speed", speed, SPI);
    check("rst_jump", jump, 0);
    check("rst_game_rst", game_rst, 0);
    check("rst_state", game_state, 0);
    check("rst_score", score, 0);
    check("rst_hi", hi_score, 0);
    rst = 1'b1;
    model_reset();

    // idle: free-running frame tick and timer
    for (int i = 0; i < 240; i++) begin
      step(0, 0);
      if (m_cyc == 239) check("timer_59", timer, 59);
    end
    check("timer_wrap", timer, 0);
    check("idle_tick_count", n_tick_obs, 60);
    check("idle_jumps", n_jump_obs, 0);
    check("idle_state", game_state, 0);

    // glitch then clean press
    j0 = n_jump_obs;
    step(1, 0); step(1, 0);
    repeat (6) step(0, 0);
    check("glitch_jump", n_jump_obs - j0, 0);
    check("glitch_state", game_state, 0);
    j0 = n_jump_obs;
    first = -1;
    for (int i = 0; i < 16; i++) begin
      step(bit'(i < 10), 0);
      if (first < 0 && last_jump) first = i;
    end
    check("jump_latency", first, 6);
    check("jump_count", n_jump_obs - j0, 1);
    check("run_state", game_state, 1);

    // crash on the same cycle as a frame tick and a press, score 3
    ok = 0;
    for (int i = 0; i < 400 && ok == 0; i++) begin
      if (exp_score() == 3 && m_score_ticks % SDIV == 0 && (m_cyc + P_LAT) % CPF == CPF - 1 &&
          !m_db && !m_db_prev && m_state == 1) ok = 1;
      else step(0, 0);
    end
    check("wait_score3", ok, 1);
    press_pulse(1, P_LAT + 1);
    check("crash_state", game_state, 2);
    check("crash_score", score, 3);
    check("crash_jump", jump, 0);
    check("crash_hi", hi_score, 3);

    // press while the over hold is still at frame 1
    ok = 0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      if (!m_db && m_state == 2 && pred_over() == 1) ok = 1;
      else step(0, 0);
    end
    check("wait_hold1", ok, 1);
    g0 = n_grst_obs;
    press_pulse(0, 10);
    check("hold_ignored", n_grst_obs - g0, 0);
    check("hold_state", game_state, 2);

    // press after the hold expires restarts the game
    wait_over_ready();
    g0 = n_grst_obs;
    press_pulse(0, 10);
    check("restart_pulses", n_grst_obs - g0, 1);
    check("restart_state", snap_state, 0);
    check("restart_score", snap_score, 0);
    check("restart_speed", snap_speed, SPI);
    check("restart_hi", snap_hi, 3);

    // second game: speed ramp and score saturation
    press_pulse(0, 10);
    wait_run(2, "wait_2f");
    check("speed_2f", speed, 7);
    wait_run(4, "wait_4f");
    check("speed_4f", speed, 8);
    wait_run(10, "wait_10f");
    check("speed_10f", speed, 8);
    check("score_10f", score, 5);
    wait_run(20, "wait_20f");
    check("score_sat", score, SMAX);
    step(0, 1);
    check("crash2_state", game_state, 2);
    check("crash2_hi", hi_score, SMAX);

    // third game, then asynchronous reset mid-run
    wait_over_ready();
    press_pulse(0, 10);
    press_pulse(0, 10);
    repeat (7) step(0, 0);
    check("pre_reset_state", game_state, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_frame_tick", frame_tick, 0);
    check("async_timer", timer, 0);
    check("async_speed", speed, SPI);
    check("async_jump", jump, 0);
    check("async_game_rst", game_rst, 0);
    check("async_state", game_state, 0);
    check("async_score", score, 0);
    check("async_hi", hi_score, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // random button and crash traffic
    for (int i = 0; i < 1500; i++) begin
      seg = $urandom_range(1, 10);
      b = bit'($urandom_range(0, 1));
      c = ($urandom_range(0, 11) == 0);
      for (int k = 0; k < seg; k++) step(b, c);
    end
    step(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
